// File: rtl/battle_pkg.sv
// Shared encodings for the battle sequencer: phases, key codes and menu items.
// Defining MERCY_EN adds the SPARE menu item.
package battle_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MENU   = 3'd1,
        ATTACK = 3'd2,
        DAMAGE = 3'd3,
        DODGE  = 3'd4,
        WIN    = 3'd5,
        LOSE   = 3'd6
    } phase_t;

    localparam logic [7:0] KEY_LEFT    = 8'h61;
    localparam logic [7:0] KEY_RIGHT   = 8'h64;
    localparam logic [7:0] KEY_CONFIRM = 8'h20;
    localparam logic [7:0] KEY_RESTART = 8'h72;

    localparam logic [1:0] ITEM_FIGHT = 2'd0;
    localparam logic [1:0] ITEM_HEAL  = 2'd1;
`ifdef MERCY_EN
    localparam logic [1:0] ITEM_SPARE = 2'd2;
    localparam logic [1:0] ITEM_LAST  = ITEM_SPARE;
`else
    localparam logic [1:0] ITEM_LAST  = ITEM_HEAL;
`endif

    function automatic logic [7:0] satSub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/attack_meter.sv
// Attack meter: tick-driven bar counter plus the distance-from-center damage table.
module attack_meter #(
    parameter int BAR_MAX = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       stop,
    input  logic [7:0] player_atk,
    output logic [7:0] bar_pos,
    output logic       done,
    output logic [7:0] dmg
);

    localparam logic [7:0] CENTER  = 8'(BAR_MAX / 2);
    localparam logic [7:0] BAR_END = 8'(BAR_MAX - 1);

    logic [7:0] distance;
    logic [8:0] doubled;
    logic [7:0] hitDmg;

    // A stop in the same cycle as a tick keeps the pre-increment position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_pos <= '0;
        end else if (clear) begin
            bar_pos <= '0;
        end else if (tick && !stop) begin
            bar_pos <= bar_pos + 8'd1;
        end
    end

    always_comb begin
        distance = (bar_pos >= CENTER) ? (bar_pos - CENTER) : (CENTER - bar_pos);
        doubled  = {player_atk, 1'b0};
        if (distance <= 8'd2) begin
            hitDmg = doubled[8] ? 8'hFF : doubled[7:0];
        end else if (distance <= 8'd6) begin
            hitDmg = player_atk;
        end else begin
            hitDmg = {1'b0, player_atk[7:1]};
        end
    end

    // Running off the end of the bar counts as a miss.
    assign done = tick && !stop && (bar_pos >= BAR_END);
    assign dmg  = done ? 8'd0 : hitDmg;

endmodule

// File: rtl/battle_sequencer.sv
// Turn-based battle controller: menu, attack meter, damage hand-off and dodge phase.
// Build option MERCY_EN adds a SPARE menu item that wins against a weakened monster.
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int MON_HP_INIT = 100,
    parameter int BAR_MAX     = 20,
    parameter int DODGE_TICKS = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [7:0] key,
    input  logic       key_valid,
    input  logic [7:0] player_atk,
    input  logic       player_dead,
    input  logic       dmg_done,
    output logic [2:0] phase,
    output logic [1:0] menu_sel,
    output logic [7:0] bar_pos,
    output logic [7:0] mon_hp,
    output logic       bullet_run,
    output logic       dmg_start,
    output logic [7:0] dmg_amount,
    output logic       heal,
    output logic       win,
    output logic       lose
);

    localparam logic [7:0]  HP_INIT    = 8'(MON_HP_INIT);
    localparam logic [15:0] DODGE_LAST = 16'(DODGE_TICKS - 1);
`ifdef MERCY_EN
    localparam logic [7:0]  SPARE_HP   = 8'(MON_HP_INIT / 4);
`endif

    phase_t      state;
    logic [15:0] dodgeCnt;
    logic        pressLeft;
    logic        pressRight;
    logic        pressConfirm;
    logic        pressRestart;
    logic        inFight;
    logic        meterTick;
    logic        meterClear;
    logic        meterStop;
    logic        meterDone;
    logic [7:0]  meterDmg;

    assign pressLeft    = key_valid && (key == KEY_LEFT);
    assign pressRight   = key_valid && (key == KEY_RIGHT);
    assign pressConfirm = key_valid && (key == KEY_CONFIRM);
    assign pressRestart = key_valid && (key == KEY_RESTART);

    assign inFight    = (state == MENU) || (state == ATTACK) || (state == DAMAGE) || (state == DODGE);
    assign meterTick  = tick && (state == ATTACK);
    assign meterStop  = pressConfirm && (state == ATTACK);
    assign meterClear = (pressConfirm && (state == MENU) && (menu_sel == ITEM_FIGHT) && !player_dead)
                      || (pressRestart && ((state == WIN) || (state == LOSE)));

    assign phase = state;

    attack_meter #(
        .BAR_MAX(BAR_MAX)
    ) meter (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (meterTick),
        .clear     (meterClear),
        .stop      (meterStop),
        .player_atk(player_atk),
        .bar_pos   (bar_pos),
        .done      (meterDone),
        .dmg       (meterDmg)
    );

    // Player death outranks every other transition while a fight is in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            menu_sel   <= ITEM_FIGHT;
            mon_hp     <= HP_INIT;
            dodgeCnt   <= '0;
            bullet_run <= 1'b0;
            dmg_start  <= 1'b0;
            dmg_amount <= '0;
            heal       <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            dmg_start <= 1'b0;
            heal      <= 1'b0;
            if (player_dead && inFight) begin
                state      <= LOSE;
                lose       <= 1'b1;
                bullet_run <= 1'b0;
                dmg_amount <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pressConfirm) state <= MENU;
                    end
                    MENU: begin
                        if (pressLeft) begin
                            menu_sel <= (menu_sel == ITEM_FIGHT) ? ITEM_LAST : menu_sel - 2'd1;
                        end else if (pressRight) begin
                            menu_sel <= (menu_sel == ITEM_LAST) ? ITEM_FIGHT : menu_sel + 2'd1;
                        end else if (pressConfirm) begin
                            case (menu_sel)
                                ITEM_FIGHT: state <= ATTACK;
                                ITEM_HEAL: begin
                                    heal       <= 1'b1;
                                    state      <= DODGE;
                                    bullet_run <= 1'b1;
                                    dodgeCnt   <= '0;
                                end
`ifdef MERCY_EN
                                ITEM_SPARE: begin
                                    if (mon_hp <= SPARE_HP) begin
                                        state <= WIN;
                                        win   <= 1'b1;
                                    end else begin
                                        state      <= DODGE;
                                        bullet_run <= 1'b1;
                                        dodgeCnt   <= '0;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                    ATTACK: begin
                        if (meterStop || meterDone) begin
                            state      <= DAMAGE;
                            dmg_start  <= 1'b1;
                            dmg_amount <= meterDmg;
                            mon_hp     <= satSub(mon_hp, meterDmg);
                        end
                    end
                    DAMAGE: begin
                        if (dmg_done) begin
                            dmg_amount <= '0;
                            if (mon_hp == 8'd0) begin
                                state <= WIN;
                                win   <= 1'b1;
                            end else begin
                                state      <= DODGE;
                                bullet_run <= 1'b1;
                                dodgeCnt   <= '0;
                            end
                        end
                    end
                    DODGE: begin
                        if (tick) begin
                            if (dodgeCnt == DODGE_LAST) begin
                                state      <= MENU;
                                bullet_run <= 1'b0;
                            end else begin
                                dodgeCnt <= dodgeCnt + 16'd1;
                            end
                        end
                    end
                    WIN, LOSE: begin
                        if (pressRestart) begin
                            mon_hp   <= HP_INIT;
                            menu_sel <= ITEM_FIGHT;
                            state    <= MENU;
                            win      <= 1'b0;
                            lose     <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: a vector table for the main flow plus hand-built corner sequences.
module tb_battle_sequencer;

`ifdef MERCY_EN
    localparam logic [1:0] LAST_ITEM = 2'd2;
`else
    localparam logic [1:0] LAST_ITEM = 2'd1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] key = 8'h00;
    logic       key_valid = 1'b0;
    logic [7:0] player_atk = 8'd30;
    logic       player_dead = 1'b0;
    logic       dmg_done = 1'b0;
    logic [2:0] phase;
    logic [1:0] menu_sel;
    logic [7:0] bar_pos;
    logic [7:0] mon_hp;
    logic       bullet_run;
    logic       dmg_start;
    logic [7:0] dmg_amount;
    logic       heal;
    logic       win;
    logic       lose;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        string      name;
        logic [7:0] key;
        logic       keyValid;
        logic       tick;
        int         reps;
        logic       dmgDone;
        logic [2:0] ePhase;
        logic [1:0] eSel;
        logic [7:0] eBar;
        logic [7:0] eHp;
        logic       eBullet;
        logic       eStart;
        logic [7:0] eAmt;
        logic       eHeal;
    } vector_t;

    vector_t vecs[$];

    battle_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .key        (key),
        .key_valid  (key_valid),
        .player_atk (player_atk),
        .player_dead(player_dead),
        .dmg_done   (dmg_done),
        .phase      (phase),
        .menu_sel   (menu_sel),
        .bar_pos    (bar_pos),
        .mon_hp     (mon_hp),
        .bullet_run (bullet_run),
        .dmg_start  (dmg_start),
        .dmg_amount (dmg_amount),
        .heal       (heal),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pressKey(input logic [7:0] k);
        key = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        key = 8'h00;
    endtask

    task automatic pulseTick(input int n);
        for (int t = 0; t < n; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] ePhase, input logic [1:0] eSel,
                               input logic [7:0] eBar, input logic [7:0] eHp, input logic eBullet,
                               input logic eStart, input logic [7:0] eAmt, input logic eHeal,
                               input logic eWin, input logic eLose);
        logic [33:0] actual;
        logic [33:0] expected;
        actual   = {phase, menu_sel, bar_pos, mon_hp, bullet_run, dmg_start, dmg_amount, heal, win, lose};
        expected = {ePhase, eSel, eBar, eHp, eBullet, eStart, eAmt, eHeal, eWin, eLose};
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got phase=%0d sel=%0d bar=%0d hp=%0d run=%0b start=%0b amt=%0d heal=%0b win=%0b lose=%0b, expected phase=%0d sel=%0d bar=%0d hp=%0d run=%0b start=%0b amt=%0d heal=%0b win=%0b lose=%0b",
                     name, phase, menu_sel, bar_pos, mon_hp, bullet_run, dmg_start, dmg_amount, heal, win, lose,
                     ePhase, eSel, eBar, eHp, eBullet, eStart, eAmt, eHeal, eWin, eLose);
        end
    endtask

    task automatic addVec(input string name, input logic [7:0] k, input logic kv, input logic tk, input int reps,
                          input logic dd, input logic [2:0] ePhase, input logic [1:0] eSel, input logic [7:0] eBar,
                          input logic [7:0] eHp, input logic eBullet, input logic eStart, input logic [7:0] eAmt,
                          input logic eHeal);
        vector_t v;
        v.name = name; v.key = k; v.keyValid = kv; v.tick = tk; v.reps = reps; v.dmgDone = dd;
        v.ePhase = ePhase; v.eSel = eSel; v.eBar = eBar; v.eHp = eHp; v.eBullet = eBullet;
        v.eStart = eStart; v.eAmt = eAmt; v.eHeal = eHeal;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vector_t v);
        for (int r = 0; r < v.reps; r++) begin
            key = v.key;
            key_valid = v.keyValid;
            tick = v.tick;
            dmg_done = v.dmgDone;
            step();
            key_valid = 1'b0;
            key = 8'h00;
            tick = 1'b0;
            dmg_done = 1'b0;
        end
        checkOutput(v.name, v.ePhase, v.eSel, v.eBar, v.eHp, v.eBullet, v.eStart, v.eAmt, v.eHeal, 1'b0, 1'b0);
    endtask

    // From MENU with FIGHT selected and full HP: strike after nTicks and return to MENU via WIN or LOSE.
    task automatic doStrike(input string name, input logic [7:0] atk, input int nTicks, input logic withTick,
                            input logic [7:0] expAmt);
        logic [7:0] expHp;
        expHp = (expAmt >= 8'd100) ? 8'd0 : 8'd100 - expAmt;
        player_atk = atk;
        pressKey(8'h20);
        checkOutput({name, "_attack"}, 3'd2, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pulseTick(nTicks);
        key = 8'h20;
        key_valid = 1'b1;
        tick = withTick;
        step();
        key_valid = 1'b0;
        key = 8'h00;
        tick = 1'b0;
        checkOutput({name, "_hit"}, 3'd3, 2'd0, 8'(nTicks), expHp, 1'b0, 1'b1, expAmt, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput({name, "_hold"}, 3'd3, 2'd0, 8'(nTicks), expHp, 1'b0, 1'b0, expAmt, 1'b0, 1'b0, 1'b0);
        dmg_done = 1'b1;
        step();
        dmg_done = 1'b0;
        if (expHp == 8'd0) begin
            checkOutput({name, "_win"}, 3'd5, 2'd0, 8'(nTicks), 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        end else begin
            checkOutput({name, "_dodge"}, 3'd4, 2'd0, 8'(nTicks), expHp, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            player_dead = 1'b1;
            step();
            player_dead = 1'b0;
        end
        pressKey(8'h72);
        checkOutput({name, "_restart"}, 3'd1, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 3'd0, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        step();

        addVec("idle",          8'h00, 1'b0, 1'b0, 1,  1'b0, 3'd0, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("idle_d_ignore", 8'h64, 1'b1, 1'b0, 1,  1'b0, 3'd0, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("to_menu",       8'h20, 1'b1, 1'b0, 1,  1'b0, 3'd1, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("left_wrap",     8'h61, 1'b1, 1'b0, 1,  1'b0, 3'd1, LAST_ITEM, 8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("right_wrap",    8'h64, 1'b1, 1'b0, 1,  1'b0, 3'd1, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("right_heal",    8'h64, 1'b1, 1'b0, 1,  1'b0, 3'd1, 2'd1,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("left_fight",    8'h61, 1'b1, 1'b0, 1,  1'b0, 3'd1, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("other_key",     8'h78, 1'b1, 1'b0, 1,  1'b0, 3'd1, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("r_in_menu",     8'h72, 1'b1, 1'b0, 1,  1'b0, 3'd1, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("tick_in_menu",  8'h00, 1'b0, 1'b1, 1,  1'b0, 3'd1, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("fight",         8'h20, 1'b1, 1'b0, 1,  1'b0, 3'd2, 2'd0,      8'd0,  8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("bar_to_10",     8'h00, 1'b0, 1'b1, 10, 1'b0, 3'd2, 2'd0,      8'd10, 8'd100, 1'b0, 1'b0, 8'd0,  1'b0);
        addVec("hit_center",    8'h20, 1'b1, 1'b0, 1,  1'b0, 3'd3, 2'd0,      8'd10, 8'd40,  1'b0, 1'b1, 8'd60, 1'b0);
        addVec("damage_wait",   8'h00, 1'b0, 1'b0, 1,  1'b0, 3'd3, 2'd0,      8'd10, 8'd40,  1'b0, 1'b0, 8'd60, 1'b0);
        addVec("damage_done",   8'h00, 1'b0, 1'b0, 1,  1'b1, 3'd4, 2'd0,      8'd10, 8'd40,  1'b1, 1'b0, 8'd0,  1'b0);
        addVec("dodge_49",      8'h00, 1'b0, 1'b1, 49, 1'b0, 3'd4, 2'd0,      8'd10, 8'd40,  1'b1, 1'b0, 8'd0,  1'b0);
        addVec("dodge_50",      8'h00, 1'b0, 1'b1, 1,  1'b0, 3'd1, 2'd0,      8'd10, 8'd40,  1'b0, 1'b0, 8'd0,  1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Meter runs off the end, then death mid-dodge and restart from LOSE.
        pressKey(8'h20);
        checkOutput("miss_attack", 3'd2, 2'd0, 8'd0, 8'd40, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pulseTick(19);
        checkOutput("miss_bar19", 3'd2, 2'd0, 8'd19, 8'd40, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        checkOutput("miss_damage", 3'd3, 2'd0, 8'd20, 8'd40, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        dmg_done = 1'b1;
        step();
        dmg_done = 1'b0;
        pulseTick(5);
        checkOutput("miss_dodge", 3'd4, 2'd0, 8'd20, 8'd40, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        player_dead = 1'b1;
        step();
        player_dead = 1'b0;
        checkOutput("dead_in_dodge", 3'd6, 2'd0, 8'd20, 8'd40, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        pressKey(8'h78);
        checkOutput("lose_hold", 3'd6, 2'd0, 8'd20, 8'd40, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        pressKey(8'h72);
        checkOutput("lose_restart", 3'd1, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        doStrike("d6",      8'd30,  4,  1'b0, 8'd30);
        doStrike("d7",      8'd30,  3,  1'b0, 8'd15);
        doStrike("d2",      8'd30,  12, 1'b0, 8'd60);
        doStrike("d3",      8'd30,  13, 1'b0, 8'd30);
        doStrike("d6_hi",   8'd30,  16, 1'b0, 8'd30);
        doStrike("d7_hi",   8'd30,  17, 1'b0, 8'd15);
        doStrike("d10",     8'd31,  0,  1'b0, 8'd15);
        doStrike("key_tick", 8'd30, 7,  1'b1, 8'd30);
        doStrike("sat200",  8'd200, 10, 1'b0, 8'd255);
        doStrike("sat128",  8'd128, 10, 1'b0, 8'd255);
        doStrike("atk127",  8'd127, 9,  1'b0, 8'd254);

        // Bring HP to 10, then a 60-point hit with dmg_done in the dmg_start cycle.
        player_atk = 8'd45;
        pressKey(8'h20);
        pulseTick(10);
        pressKey(8'h20);
        checkOutput("hp10_hit", 3'd3, 2'd0, 8'd10, 8'd10, 1'b0, 1'b1, 8'd90, 1'b0, 1'b0, 1'b0);
        dmg_done = 1'b1;
        step();
        dmg_done = 1'b0;
        pulseTick(50);
        checkOutput("hp10_menu", 3'd1, 2'd0, 8'd10, 8'd10, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        player_atk = 8'd30;
        pressKey(8'h20);
        pulseTick(10);
        pressKey(8'h20);
        checkOutput("kill_hit", 3'd3, 2'd0, 8'd10, 8'd0, 1'b0, 1'b1, 8'd60, 1'b0, 1'b0, 1'b0);
        dmg_done = 1'b1;
        step();
        dmg_done = 1'b0;
        checkOutput("kill_win", 3'd5, 2'd0, 8'd10, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        pressKey(8'h72);
        checkOutput("win_restart", 3'd1, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Heal pulse and dodge length; menu_sel must survive the dodge.
        pressKey(8'h64);
        pressKey(8'h20);
        checkOutput("heal_pulse", 3'd4, 2'd1, 8'd0, 8'd100, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("heal_once", 3'd4, 2'd1, 8'd0, 8'd100, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pulseTick(49);
        checkOutput("heal_dodge49", 3'd4, 2'd1, 8'd0, 8'd100, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pulseTick(1);
        checkOutput("heal_dodge50", 3'd1, 2'd1, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while waiting for dmg_done.
        pressKey(8'h61);
        pressKey(8'h20);
        pulseTick(10);
        pressKey(8'h20);
        checkOutput("pre_reset_hit", 3'd3, 2'd0, 8'd10, 8'd40, 1'b0, 1'b1, 8'd60, 1'b0, 1'b0, 1'b0);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 3'd0, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        step();
        checkOutput("after_reset", 3'd0, 2'd0, 8'd0, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

`ifdef MERCY_EN
        pressKey(8'h20);
        player_atk = 8'd75;
        pressKey(8'h20);
        pulseTick(4);
        pressKey(8'h20);
        dmg_done = 1'b1;
        step();
        dmg_done = 1'b0;
        pulseTick(50);
        checkOutput("hp25_menu", 3'd1, 2'd0, 8'd4, 8'd25, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pressKey(8'h61);
        checkOutput("sel_spare", 3'd1, 2'd2, 8'd4, 8'd25, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pressKey(8'h20);
        checkOutput("spare_win", 3'd5, 2'd2, 8'd4, 8'd25, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        pressKey(8'h72);
        player_atk = 8'd74;
        pressKey(8'h20);
        pulseTick(4);
        pressKey(8'h20);
        dmg_done = 1'b1;
        step();
        dmg_done = 1'b0;
        pulseTick(50);
        checkOutput("hp26_menu", 3'd1, 2'd0, 8'd4, 8'd26, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        pressKey(8'h61);
        pressKey(8'h20);
        checkOutput("spare_dodge", 3'd4, 2'd2, 8'd4, 8'd26, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
